avalon_pio_out: RTL and testbench
=================================

Name: avalon_pio_out

Overview:
Avalon-MM slave output port (PIO) that drives board LEDs and other control lines from Nios II software. It is the write-side counterpart of the switch input PIOs in the t_vga_v1 system. The block holds a data register that software can write whole or modify per bit through set/clear strobes. It uses registered one-cycle read latency, identical to the input PIOs, so both share the same Qsys timing settings.

Parameters:
WIDTH, 8, number of output bits (1..32)
RESET_VALUE, 0, value loaded into the data register and out_port at reset
BLINK_DIV, 25000000, blink half-period in clk cycles (>=2); used only with PIO_OUT_BLINK_EN

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  3  Avalon word address
chipselect  input  1  Avalon slave select
write_n  input  1  Avalon write strobe, active-low
writedata  input  32  Avalon write data; bits above WIDTH-1 ignored
readdata  output  32  Avalon read data, registered, zero-extended
out_port  output  WIDTH  driven output pins

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. While reset_n=0: data_reg=RESET_VALUE, readdata=0, blink_mask=0, blink counter=0, blink phase=0.
- Write qualifier: wr = chipselect & ~write_n. A write takes effect at the clk edge on which wr is sampled high. There are no wait states.
- Register map (word address):
  - 0 DATA: R/W. Write sets data_reg=writedata[WIDTH-1:0].
  - 1 DIRECTION: reserved. Reads 0, writes ignored.
  - 2 BLINKMASK: R/W; see Optional Feature.
  - 3: reserved. Reads 0.
  - 4 OUTSET: W. Write sets data_reg |= writedata[WIDTH-1:0]. Reads 0.
  - 5 OUTCLEAR: W. Write sets data_reg &= ~writedata[WIDTH-1:0]. Reads 0.
  - 6, 7: reserved. Reads 0, writes ignored.
- Read path: readdata is registered every clk, independent of chipselect, equal to the zero-extended mux of address. Read latency is 1 cycle. A DATA read returns data_reg, not the blinked out_port value.
- Read during write to the same address: readdata returns the pre-write value, because the register updates on the same edge on which readdata samples it.
- out_port: registered copy of data_reg. It changes 1 cycle after the write edge, i.e. out_port lags data_reg by one clk; no combinational path from the bus.
- A write with write_n=0 and chipselect=0 is ignored.
- Mid-operation reset: all state returns to reset values immediately. No partial write survives.

Optional Feature:
Macro PIO_OUT_BLINK_EN.
- Defined:
  - Prescaler counter runs 0..BLINK_DIV-1 and wraps to 0. At the wrap, the phase bit toggles.
  - out_port <= data_reg ^ (blink_mask & {WIDTH{phase}}).
  - Writing BLINKMASK loads blink_mask, clears the counter, and clears the phase. The first toggle therefore occurs BLINK_DIV cycles after the write edge.
  - A bit with mask=1 whose data_reg bit is 0 blinks starting dark.
  - Reads of BLINKMASK return blink_mask.
- Undefined: no counter logic. Address 2 reads 0 and writes are ignored. out_port <= data_reg.

Decomposition:
- Package pio_out_pkg: address constants ADDR_DATA=3'd0, ADDR_DIR=3'd1, ADDR_BLINK=3'd2, ADDR_OUTSET=3'd4, ADDR_OUTCLR=3'd5; and a function returning the counter width as $clog2(BLINK_DIV).
- One sub-module, pio_blink_prescaler (BLINK_DIV parameter; inputs clk, reset_n, clear; output phase). It is instantiated only under PIO_OUT_BLINK_EN.

Test Plan:
- Reset: hold reset_n=0 with RESET_VALUE=8'hA5 -> out_port=8'hA5, readdata=0. Release, then read addr 0 -> readdata=32'h000000A5 one cycle after the address is presented.
- Write/readback: write addr0 data 32'hFFFF_FF3C -> out_port=8'h3C one cycle later; read addr0 -> 32'h0000003C; read addr1, addr6 -> 0.
- Set/clear: starting from data 8'h3C, write OUTSET 8'h81 -> 8'hBD; write OUTCLEAR 8'h0C -> 8'hB1; reads of addr4/5 -> 0.
- Qualifier: write_n=0 with chipselect=0 to addr0 data 8'hFF -> data unchanged. Back-to-back writes to addr0 (8'h01, 8'h02) on consecutive cycles -> out_port shows 01 then 02 on successive cycles.
- Blink (PIO_OUT_BLINK_EN, BLINK_DIV=4): data=8'h00, write BLINKMASK 8'h0F -> out_port toggles between 8'h00 and 8'h0F every 4 cycles. Readback of addr2 -> 8'h0F. Rewrite of the mask mid-period restarts the period with phase 0.
- Async reset mid-blink: assert reset_n between clk edges -> out_port returns to RESET_VALUE immediately, and blinking stays off after release.

Source files
------------

// File: rtl/pio_out_pkg.sv
// Shared constants and helpers for the Avalon output PIO.
// Register word addresses and blink prescaler sizing.
package pio_out_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_BLINK  = 3'd2;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  function automatic int cnt_width(input int div);
    return $clog2(div);
  endfunction

endpackage

// File: rtl/pio_blink_prescaler.sv
// Free-running divider that toggles a phase bit every BLINK_DIV cycles.
// A clear pulse restarts the count with phase 0.
module pio_blink_prescaler
  import pio_out_pkg::*;
#(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic phase
);

  localparam int CW = cnt_width(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (clear) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/avalon_pio_out.sv
// Avalon-MM output PIO with set/clear strobes and 1-cycle registered reads.
// Optional per-bit blinking is built when PIO_OUT_BLINK_EN is defined.
module avalon_pio_out
  import pio_out_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               BLINK_DIV   = 25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr;
  logic             wr_data, wr_set, wr_clr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [31:0]      rd_q, rd_d;
  logic [WIDTH-1:0] blink_ov;

  assign wr      = chipselect & ~write_n;
  assign wdata   = writedata[WIDTH-1:0];
  assign wr_data = wr && (address == ADDR_DATA);
  assign wr_set  = wr && (address == ADDR_OUTSET);
  assign wr_clr  = wr && (address == ADDR_OUTCLR);

`ifdef PIO_OUT_BLINK_EN
  logic             wr_blink;
  logic             phase;
  logic [WIDTH-1:0] mask_q, mask_d;

  assign wr_blink = wr && (address == ADDR_BLINK);

  always_comb begin
    mask_d = mask_q;
    if (wr_blink) mask_d = wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mask_q <= '0;
    else          mask_q <= mask_d;
  end

  pio_blink_prescaler #(
    .BLINK_DIV (BLINK_DIV)
  ) u_presc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wr_blink),
    .phase   (phase)
  );

  assign blink_ov = mask_q & {WIDTH{phase}};
`else
  logic unused_div;
  assign unused_div = ^BLINK_DIV;
  assign blink_ov   = '0;
`endif

  logic unused_wd;
  assign unused_wd = ^writedata;

  always_comb begin
    data_d = data_q;
    unique case (1'b1)
      wr_data: data_d = wdata;
      wr_set:  data_d = data_q | wdata;
      wr_clr:  data_d = data_q & ~wdata;
      default: ;
    endcase
  end

  // DATA reads return the register, never the blinked pins
  always_comb begin
    rd_d = '0;
    if (address == ADDR_DATA) rd_d = 32'(data_q);
`ifdef PIO_OUT_BLINK_EN
    if (address == ADDR_BLINK) rd_d = 32'(mask_q);
`endif
  end

  assign out_d = data_q ^ blink_ov;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      out_q  <= RESET_VALUE;
      rd_q   <= '0;
    end else begin
      data_q <= data_d;
      out_q  <= out_d;
      rd_q   <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign out_port = out_q;

endmodule

// File: tb/tb_avalon_pio_out.sv
// Self-checking bench for avalon_pio_out: directed table, blink and
// reset sequences, then random traffic against a behavioural model.
module tb_avalon_pio_out;

  localparam int         DIV = 4;
  localparam logic [7:0] RV  = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  always #5 clk = ~clk;

  avalon_pio_out #(
    .WIDTH       (8),
    .RESET_VALUE (RV),
    .BLINK_DIV   (DIV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: register contents plus cycles elapsed since the blink restart
  logic [7:0]  data_m;
  logic [7:0]  mask_m;
  int          k_m;
  logic [31:0] exp_rd;
  logic [7:0]  exp_out;

  typedef struct {
    bit          cs;
    bit          wn;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  out;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    data_m  = RV;
    mask_m  = 8'h00;
    k_m     = 0;
    exp_rd  = 32'h0;
    exp_out = RV;
  endtask

  task automatic model_step(input logic cs, input logic wn,
                            input logic [2:0] addr,
                            input logic [31:0] wd);
    logic wr;
    logic ph;
    wr = cs && !wn;
    ph = ((k_m / DIV) % 2) == 1;
    exp_out = data_m ^ (ph ? mask_m : 8'h00);
    exp_rd  = 32'h0;
    if (addr == 3'd0) exp_rd = {24'h0, data_m};
`ifdef PIO_OUT_BLINK_EN
    if (addr == 3'd2) exp_rd = {24'h0, mask_m};
`endif
    k_m++;
    if (wr) begin
      case (addr)
        3'd0: data_m = wd[7:0];
        3'd4: data_m = data_m | wd[7:0];
        3'd5: data_m = data_m & ~wd[7:0];
`ifdef PIO_OUT_BLINK_EN
        3'd2: begin
          mask_m = wd[7:0];
          k_m    = 0;
        end
`endif
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input logic cs, input logic wn,
                       input logic [2:0] addr, input logic [31:0] wd);
    chipselect = cs;
    write_n    = wn;
    address    = addr;
    writedata  = wd;
    @(posedge clk);
    model_step(cs, wn, addr, wd);
    #1;
    chk("rd", readdata, exp_rd);
    chk("out", {24'h0, out_port}, {24'h0, exp_out});
  endtask

  task automatic idle(input logic [2:0] addr);
    cycle(1'b1, 1'b1, addr, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{1, 1, 3'd0, 32'h0,        32'hA5, 8'hA5};
    tbl[1]  = '{1, 0, 3'd0, 32'hFFFFFF3C, 32'hA5, 8'hA5};
    tbl[2]  = '{1, 1, 3'd0, 32'h0,        32'h3C, 8'h3C};
    tbl[3]  = '{1, 1, 3'd1, 32'h0,        32'h00, 8'h3C};
    tbl[4]  = '{1, 1, 3'd6, 32'h0,        32'h00, 8'h3C};
    tbl[5]  = '{1, 0, 3'd4, 32'h81,       32'h00, 8'h3C};
    tbl[6]  = '{1, 1, 3'd0, 32'h0,        32'hBD, 8'hBD};
    tbl[7]  = '{1, 0, 3'd5, 32'h0C,       32'h00, 8'hBD};
    tbl[8]  = '{1, 1, 3'd0, 32'h0,        32'hB1, 8'hB1};
    tbl[9]  = '{1, 1, 3'd5, 32'h0,        32'h00, 8'hB1};
    tbl[10] = '{0, 0, 3'd0, 32'hFF,       32'hB1, 8'hB1};
    tbl[11] = '{1, 1, 3'd0, 32'h0,        32'hB1, 8'hB1};
    tbl[12] = '{1, 0, 3'd0, 32'h01,       32'hB1, 8'hB1};
    tbl[13] = '{1, 0, 3'd0, 32'h02,       32'h01, 8'h01};
    tbl[14] = '{1, 1, 3'd0, 32'h0,        32'h02, 8'h02};
    tbl[15] = '{1, 0, 3'd1, 32'hFF,       32'h00, 8'h02};
    tbl[16] = '{1, 0, 3'd7, 32'hFF,       32'h00, 8'h02};
    tbl[17] = '{1, 1, 3'd0, 32'h0,        32'h02, 8'h02};
    tbl[18] = '{1, 1, 3'd2, 32'h0,        32'h00, 8'h02};

    model_reset();
    #12;
    chk("reset_out", {24'h0, out_port}, 32'hA5);
    chk("reset_rd", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd);
      chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].rd);
      chk($sformatf("tbl%0d_out", i), {24'h0, out_port},
          {24'h0, tbl[i].out});
      @(negedge clk);
    end

`ifdef PIO_OUT_BLINK_EN
    cycle(1'b1, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    cycle(1'b1, 1'b0, 3'd2, 32'h0F);
    @(negedge clk);
    for (int i = 1; i <= 14; i++) begin
      cycle(1'b1, 1'b1, 3'd2, 32'h0);
      if (i == 1) chk("mask_rd", readdata, 32'h0F);
      if (i == 4) chk("blink_dark", {24'h0, out_port}, 32'h00);
      if (i == 5) chk("blink_lit", {24'h0, out_port}, 32'h0F);
      if (i == 9) chk("blink_dark2", {24'h0, out_port}, 32'h00);
      @(negedge clk);
    end
    cycle(1'b1, 1'b0, 3'd2, 32'h0F);
    @(negedge clk);
    cycle(1'b1, 1'b1, 3'd0, 32'h0);
    chk("restart_dark", {24'h0, out_port}, 32'h00);
    @(negedge clk);
    for (int i = 0; i < 5; i++) idle(3'd0);
    chk("pre_reset_lit", {24'h0, out_port}, 32'h0F);
`else
    cycle(1'b1, 1'b0, 3'd0, 32'h0);
    @(negedge clk);
    idle(3'd0);
    chk("pre_reset", {24'h0, out_port}, 32'h00);
`endif

    #2;
    reset_n = 1'b0;
    #1;
    chk("async_out", {24'h0, out_port}, 32'hA5);
    chk("async_rd", readdata, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) idle(3'd2);
    chk("post_reset_out", {24'h0, out_port}, 32'hA5);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 2) != 0,
            3'($urandom_range(0, 7)), $urandom);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
